xy_beam_scheduler: RTL

- Shares the single BNC XY DAC path (8-bit X, 7-bit Y, beam trigger) between N_SRC point-stream generators (shape/text/demo engines).
- Arbitrates round-robin at burst granularity, using a valid/ready point handshake.
- Holds each accepted point for a programmable dwell time, and blanks the beam while the DACs settle after a source switch.
- Sits between the generators and the PMOD output mux; its outputs replace the free-running BNC demo signals.

---
 rtl/xy_pkg.sv | 24 ++
 rtl/xy_beam_scheduler_if.sv | 41 ++++
 rtl/xy_beam_scheduler_rr_arbiter.sv | 51 +++++
 rtl/xy_beam_scheduler.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/xy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xy_pkg
// Description : Shared types and constants for the XY beam scheduler slice.
// Revision    : 1.0 - initial release
// ============================================================================
package xy_pkg;

    // Default coordinate widths of the BNC XY DAC path
    localparam int c_X_W_DFLT = 8;
    localparam int c_Y_W_DFLT = 7;

    // Stalled ARB cycles a locked source may hold the beam before losing it
    localparam int c_LOCK_TIMEOUT = 63;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DWELL  = 2'd2
    } xy_state_e;

endpackage
`default_nettype wire

// File: rtl/xy_beam_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : xy_beam_scheduler_if
// Description : Point-stream bus between N_SRC generators and the scheduler.
//               Packed coordinates: source i at [i*W +: W].
// Revision    : 1.0 - initial release
// ============================================================================
interface xy_beam_scheduler_if
    import xy_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int X_W   = c_X_W_DFLT,
    parameter int Y_W   = c_Y_W_DFLT
);

    logic [N_SRC-1:0]     src_valid;
    logic [N_SRC*X_W-1:0] src_x;
    logic [N_SRC*Y_W-1:0] src_y;
    logic [N_SRC-1:0]     src_last;
    logic [N_SRC-1:0]     src_ready;

    // Generator side
    modport master (
        output src_valid,
        output src_x,
        output src_y,
        output src_last,
        input  src_ready
    );

    // Scheduler side
    modport slave (
        input  src_valid,
        input  src_x,
        input  src_y,
        input  src_last,
        output src_ready
    );

endinterface
`default_nettype wire

// File: rtl/xy_beam_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. With lock set only the
//               locked id may win; otherwise the search starts one past
//               rr_ptr and wraps at N_SRC-1 back to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import xy_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
) (
    input  wire logic [N_SRC-1:0] req_i,
    input  wire logic [ID_W-1:0]  rr_ptr_i,
    input  wire logic             lock_i,
    input  wire logic [ID_W-1:0]  lock_id_i,
    output logic      [N_SRC-1:0] gnt_o,
    output logic      [ID_W-1:0]  gnt_id_o,
    output logic                  gnt_vld_o
);

    int              w_idx;
    logic            w_found;
    logic [ID_W-1:0] w_gnt_id;

    // Walk candidates from lowest to highest priority so the last hit wins
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = lock_id_i;
        w_idx    = 0;
        if (lock_i) begin
            w_found = req_i[lock_id_i];
        end else begin
            for (int k = N_SRC; k >= 1; k--) begin
                w_idx = (int'(rr_ptr_i) + k) % N_SRC;
                if (req_i[ID_W'(w_idx)]) begin
                    w_found  = 1'b1;
                    w_gnt_id = ID_W'(w_idx);
                end
            end
        end
    end

    assign gnt_vld_o = w_found;
    assign gnt_id_o  = w_gnt_id;
    assign gnt_o     = w_found ? (N_SRC'(1) << w_gnt_id) : '0;

endmodule
`default_nettype wire

// File: rtl/xy_beam_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : xy_beam_scheduler
// Description : Shares the BNC XY DAC path between N_SRC point generators.
//               Burst-granular round-robin arbitration, programmable dwell
//               per point, and a blanked settle window after a source switch.
//               Optional macro XY_LOCK_TIMEOUT_EN: a locked source stalled
//               for c_LOCK_TIMEOUT ARB cycles loses the beam.
// Revision    : 1.0 - initial release
// ============================================================================
module xy_beam_scheduler
    import xy_pkg::*;
#(
    parameter int N_SRC   = 4,
    parameter int X_W     = c_X_W_DFLT,
    parameter int Y_W     = c_Y_W_DFLT,
    parameter int DWELL_W = 4,
    parameter int SETTLE  = 2
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    enable,
    input  wire logic [DWELL_W-1:0]      dwell,
    xy_beam_scheduler_if.slave           src,
    output logic [X_W-1:0]               bnc_x,
    output logic [Y_W-1:0]               bnc_y,
    output logic                         bnc_trig,
    output logic [$clog2(N_SRC)-1:0]     grant_id,
    output logic                         busy
);

    localparam int ID_W  = $clog2(N_SRC);
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    xy_state_e           state_q,      state_d;
    logic [X_W-1:0]      x_q,          x_d;
    logic [Y_W-1:0]      y_q,          y_d;
    logic [ID_W-1:0]     grant_id_q,   grant_id_d;
    logic [ID_W-1:0]     rr_ptr_q,     rr_ptr_d;
    logic                lock_q,       lock_d;
    logic                prev_vld_q,   prev_vld_d;
    logic [DWELL_W-1:0]  dwell_cnt_q,  dwell_cnt_d;
    logic [SET_W-1:0]    settle_cnt_q, settle_cnt_d;

`ifdef XY_LOCK_TIMEOUT_EN
    logic [5:0]          starve_q,     starve_d;
`endif

    logic [N_SRC-1:0]    w_gnt_oh;
    logic [ID_W-1:0]     w_gnt_id;
    logic                w_gnt_vld;
    logic                w_accept;
    logic                w_last;

    rr_arbiter #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_arb (
        .req_i     (src.src_valid),
        .rr_ptr_i  (rr_ptr_q),
        .lock_i    (lock_q),
        .lock_id_i (grant_id_q),
        .gnt_o     (w_gnt_oh),
        .gnt_id_o  (w_gnt_id),
        .gnt_vld_o (w_gnt_vld)
    );

    // Accept only in ARB, with enable, and never during the reset cycle
    assign w_accept      = rst_n && enable && w_gnt_vld && (state_q == ST_ARB);
    assign w_last        = src.src_last[w_gnt_id];
    assign src.src_ready = w_accept ? w_gnt_oh : '0;

    // Next-state and datapath updates; every _d defaults to hold
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        grant_id_d   = grant_id_q;
        rr_ptr_d     = rr_ptr_q;
        lock_d       = lock_q;
        prev_vld_d   = prev_vld_q;
        dwell_cnt_d  = dwell_cnt_q;
        settle_cnt_d = settle_cnt_q;
`ifdef XY_LOCK_TIMEOUT_EN
        starve_d     = starve_q;
`endif
        case (state_q)
            ST_ARB: begin
                // A disabled scheduler releases any burst lock
                if (!enable) begin
                    lock_d = 1'b0;
                end
`ifdef XY_LOCK_TIMEOUT_EN
                if (w_accept || !lock_q) begin
                    starve_d = '0;
                end else if (enable && !src.src_valid[grant_id_q]) begin
                    if (starve_q == 6'(c_LOCK_TIMEOUT - 1)) begin
                        lock_d   = 1'b0;
                        rr_ptr_d = grant_id_q;
                        starve_d = '0;
                    end else begin
                        starve_d = starve_q + 6'd1;
                    end
                end
`endif
                if (w_accept) begin
                    x_d         = src.src_x[int'(w_gnt_id) * X_W +: X_W];
                    y_d         = src.src_y[int'(w_gnt_id) * Y_W +: Y_W];
                    dwell_cnt_d = dwell;
                    grant_id_d  = w_gnt_id;
                    lock_d      = ~w_last;
                    if (w_last) begin
                        rr_ptr_d = w_gnt_id;
                    end
                    // Blank while the DACs slew to a different source
                    if ((w_gnt_id != grant_id_q) || !prev_vld_q) begin
                        state_d      = ST_SETTLE;
                        settle_cnt_d = SET_W'(SETTLE - 1);
                    end else begin
                        state_d = ST_DWELL;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == '0) begin
                    state_d = ST_DWELL;
                end else begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end
            end
            ST_DWELL: begin
                if (dwell_cnt_q == '0) begin
                    state_d    = ST_ARB;
                    prev_vld_d = 1'b1;
                end else begin
                    dwell_cnt_d = dwell_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_ARB;
            x_q          <= '0;
            y_q          <= '0;
            grant_id_q   <= '0;
            rr_ptr_q     <= ID_W'(N_SRC - 1);
            lock_q       <= 1'b0;
            prev_vld_q   <= 1'b0;
            dwell_cnt_q  <= '0;
            settle_cnt_q <= '0;
`ifdef XY_LOCK_TIMEOUT_EN
            starve_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            grant_id_q   <= grant_id_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_q       <= lock_d;
            prev_vld_q   <= prev_vld_d;
            dwell_cnt_q  <= dwell_cnt_d;
            settle_cnt_q <= settle_cnt_d;
`ifdef XY_LOCK_TIMEOUT_EN
            starve_q     <= starve_d;
`endif
        end
    end

    assign bnc_x    = x_q;
    assign bnc_y    = y_q;
    assign bnc_trig = (state_q == ST_DWELL);
    assign grant_id = grant_id_q;
    assign busy     = (state_q != ST_ARB) || lock_q;

endmodule
`default_nettype wire
